// File: rtl/path_metric_mem.sv
// rtl/path_metric_mem.sv - Viterbi path-metric register bank with MSB renormalisation and best-state search
module path_metric_mem #(
    parameter int NUM_STATES = 4,
    parameter int METRIC_W   = 3,
    localparam int PM_W      = NUM_STATES * METRIC_W,
    localparam int SEL_W     = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              in_valid,
    input  logic [PM_W-1:0]   pm_in,
    output logic [PM_W-1:0]   pm_out,
    output logic              out_valid,
    output logic [SEL_W-1:0]  best_state,
    output logic              norm_flag,
    output logic [15:0]       norm_count
);

    // State 0 starts at zero, every other state starts at the worst metric.
    localparam logic [PM_W-1:0] INIT_PM = {{(PM_W - METRIC_W){1'b1}}, {METRIC_W{1'b0}}};

    logic [NUM_STATES-1:0] msb_vec;
    logic                  norm_cond;
    logic [PM_W-1:0]       pm_norm;
    logic [SEL_W-1:0]      min_idx;

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_slot
        assign msb_vec[i] = pm_in[i*METRIC_W + METRIC_W - 1];
        assign pm_norm[i*METRIC_W +: METRIC_W] = norm_cond
            ? {1'b0, pm_in[i*METRIC_W +: METRIC_W-1]}
            : pm_in[i*METRIC_W +: METRIC_W];
    end

    assign norm_cond = &msb_vec;

    // Pairwise reduction tree; on a tie the left (lower-index) operand survives.
    function automatic logic [SEL_W-1:0] min_index(input logic [PM_W-1:0] pm);
        logic [METRIC_W-1:0] val [NUM_STATES];
        logic [SEL_W-1:0]    idx [NUM_STATES];
        for (int i = 0; i < NUM_STATES; i++) begin
            val[i] = pm[i*METRIC_W +: METRIC_W];
            idx[i] = SEL_W'(i);
        end
        for (int w = NUM_STATES / 2; w >= 1; w = w / 2) begin
            for (int j = 0; j < w; j++) begin
                if (val[2*j+1] < val[2*j]) begin
                    val[j] = val[2*j+1];
                    idx[j] = idx[2*j+1];
                end else begin
                    val[j] = val[2*j];
                    idx[j] = idx[2*j];
                end
            end
        end
        return idx[0];
    endfunction

    assign min_idx = min_index(pm_norm);

    always_ff @(posedge clk) begin
        if (!rst_n || init) begin
            pm_out     <= INIT_PM;
            out_valid  <= 1'b0;
            best_state <= '0;
            norm_flag  <= 1'b0;
            norm_count <= 16'd0;
        end else if (in_valid) begin
            pm_out     <= pm_norm;
            out_valid  <= 1'b1;
            best_state <= min_idx;
            norm_flag  <= norm_cond;
            if (norm_cond && norm_count != 16'hFFFF) begin
                norm_count <= norm_count + 16'd1;
            end
        end else begin
            out_valid <= 1'b0;
            norm_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_path_metric_mem.sv
// tb/tb_path_metric_mem.sv - table-driven and model-checked bench for path_metric_mem
module tb_path_metric_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_n;
    logic        init_a, v_a;
    logic [11:0] pm_in_a, pm_out_a;
    logic        ov_a, nf_a;
    logic [1:0]  best_a;
    logic [15:0] nc_a;

    logic         init_b, v_b;
    logic [511:0] pm_in_b, pm_out_b;
    logic         ov_b, nf_b;
    logic [5:0]   best_b;
    logic [15:0]  nc_b;

    path_metric_mem dut (
        .clk(clk), .rst_n(rst_n), .init(init_a), .in_valid(v_a), .pm_in(pm_in_a),
        .pm_out(pm_out_a), .out_valid(ov_a), .best_state(best_a),
        .norm_flag(nf_a), .norm_count(nc_a)
    );

    path_metric_mem #(.NUM_STATES(64), .METRIC_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .init(init_b), .in_valid(v_b), .pm_in(pm_in_b),
        .pm_out(pm_out_b), .out_valid(ov_b), .best_state(best_b),
        .norm_flag(nf_b), .norm_count(nc_b)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        init;
        logic        v;
        logic [11:0] pm;
        logic [11:0] e_pm;
        logic [1:0]  e_best;
        logic        e_ov;
        logic        e_nf;
        logic [15:0] e_nc;
    } vec_t;

    vec_t vecs[17];

    logic [511:0] m_pm;
    logic [5:0]   m_best;
    logic [15:0]  m_nc;
    logic         m_ov, m_nf;

    function automatic logic [511:0] init_pattern64();
        logic [511:0] p;
        p = '1;
        p[7:0] = 8'h00;
        return p;
    endfunction

    task automatic m64_cycle(input logic i_init, input logic i_v, input logic [511:0] i_pm,
                             input logic do_check);
        logic       allm;
        logic [7:0] s, mn;
        init_b  = i_init;
        v_b     = i_v;
        pm_in_b = i_pm;
        @(posedge clk);
        if (i_init) begin
            m_pm = init_pattern64(); m_best = 0; m_nc = 0; m_ov = 0; m_nf = 0;
        end else if (i_v) begin
            allm = 1'b1;
            for (int k = 0; k < 64; k++) allm = allm & i_pm[k*8+7];
            m_pm = i_pm;
            if (allm) for (int k = 0; k < 64; k++) m_pm[k*8+7] = 1'b0;
            m_nf = allm;
            m_ov = 1'b1;
            if (allm && m_nc != 16'hFFFF) m_nc = m_nc + 16'd1;
            mn = 8'hFF; m_best = 0;
            for (int k = 0; k < 64; k++) begin
                s = m_pm[k*8 +: 8];
                if (k == 0 || s < mn) begin mn = s; m_best = 6'(k); end
            end
        end else begin
            m_ov = 0; m_nf = 0;
        end
        #1;
        if (do_check) begin
            check("b_pm_out", pm_out_b, m_pm);
            check("b_best", 512'(best_b), 512'(m_best));
            check("b_count", 512'(nc_b), 512'(m_nc));
            check("b_out_valid", 512'(ov_b), 512'(m_ov));
            check("b_norm_flag", 512'(nf_b), 512'(m_nf));
        end
    endtask

    function automatic logic [511:0] rand_pm64(input logic force_norm);
        logic [511:0] p;
        for (int k = 0; k < 16; k++) p[k*32 +: 32] = $urandom;
        if (force_norm) for (int k = 0; k < 64; k++) p[k*8+7] = 1'b1;
        return p;
    endfunction

    initial begin
        rst_n = 1'b0; init_a = 0; v_a = 0; pm_in_a = 0;
        init_b = 0; v_b = 0; pm_in_b = 0;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 12'h752, 12'h752, 2'd0, 1'b1, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 12'hBA7, 12'h283, 2'd1, 1'b1, 1'b1, 16'd1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h283, 2'd1, 1'b0, 1'b0, 16'd1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 12'hFFF, 12'h283, 2'd1, 1'b0, 1'b0, 16'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h283, 2'd1, 1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 12'hBA7, 12'h283, 2'd1, 1'b1, 1'b1, 16'd2};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 12'hBA7, 12'h283, 2'd1, 1'b1, 1'b1, 16'd3};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 12'hBA7, 12'h283, 2'd1, 1'b1, 1'b1, 16'd4};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 12'hBA7, 12'h283, 2'd1, 1'b1, 1'b1, 16'd5};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 12'h752, 12'hFF8, 2'd0, 1'b0, 1'b0, 16'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 12'h3A2, 12'h3A2, 2'd3, 1'b1, 1'b0, 16'd0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 12'hFFF, 12'h6DB, 2'd0, 1'b1, 1'b1, 16'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 12'h924, 12'h000, 2'd0, 1'b1, 1'b1, 16'd2};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 12'hB7F, 12'h25B, 2'd2, 1'b1, 1'b1, 16'd3};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 12'hFCC, 12'hFCC, 2'd1, 1'b1, 1'b0, 16'd3};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 12'h752, 12'hFF8, 2'd0, 1'b0, 1'b0, 16'd0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 12'h000, 12'h000, 2'd0, 1'b1, 1'b0, 16'd0};

        // reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        check("rst_pm_out", 512'(pm_out_a), 512'(12'hFF8));
        check("rst_best", 512'(best_a), 512'(0));
        check("rst_out_valid", 512'(ov_a), 512'(0));
        check("rst_norm_flag", 512'(nf_a), 512'(0));
        check("rst_count", 512'(nc_a), 512'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            rst_n   = vecs[i].rst_n;
            init_a  = vecs[i].init;
            v_a     = vecs[i].v;
            pm_in_a = vecs[i].pm;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pm_out", i), 512'(pm_out_a), 512'(vecs[i].e_pm));
            check($sformatf("v%0d_best", i), 512'(best_a), 512'(vecs[i].e_best));
            check($sformatf("v%0d_out_valid", i), 512'(ov_a), 512'(vecs[i].e_ov));
            check($sformatf("v%0d_norm_flag", i), 512'(nf_a), 512'(vecs[i].e_nf));
            check($sformatf("v%0d_count", i), 512'(nc_a), 512'(vecs[i].e_nc));
        end
        rst_n = 1'b1; init_a = 0; v_a = 0;

        // 64-state instance: reset pattern
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_pm = init_pattern64(); m_best = 0; m_nc = 0; m_ov = 0; m_nf = 0;
        check("b_rst_pm_out", pm_out_b, init_pattern64());
        check("b_rst_best", 512'(best_b), 512'(0));
        check("b_rst_count", 512'(nc_b), 512'(0));

        for (int i = 0; i < 400; i++) begin
            m64_cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                      rand_pm64($urandom_range(0, 1) == 1), 1'b1);
        end

        // saturation of the normalisation counter
        m64_cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 65534; i++) begin
            m64_cycle(1'b0, 1'b1, rand_pm64(1'b1), 1'b0);
        end
        check("b_count_fffe", 512'(nc_b), 512'(16'hFFFE));
        for (int i = 0; i < 3; i++) begin
            m64_cycle(1'b0, 1'b1, rand_pm64(1'b1), 1'b1);
            check($sformatf("b_sat%0d", i), 512'(nc_b), 512'(16'hFFFF));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
